// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared constants, state encoding and helpers for the hex telemetry framer
//
// Purpose: ASCII constants, framer FSM state encoding, nibble-to-ASCII
// conversion and frame geometry helpers shared by the framer files.
// Ports: none (package).

package telemetry_pkg;

   localparam logic [7:0] SP    = 8'h20;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] COLON = 8'h3A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECIDE,
      ST_SNAP,
      ST_LOAD,
      ST_START,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } state_t;

   // 0..9 -> '0'..'9', A..F -> 'A'..'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic int hex_digits(input int data_w);
      return (data_w + 3) / 4;
   endfunction

   // seq prefix + all hex fields + separators + CR LF
   function automatic int frame_len(input int num_ch, input int data_w, input int seq_en);
      return 3 * seq_en + num_ch * hex_digits(data_w) + num_ch - 1 + 2;
   endfunction

endpackage

// File: rtl/framer_byte_sel.sv
// rtl/framer_byte_sel.sv - maps a frame byte index to its ASCII byte
//
// Purpose: combinational byte mux over the snapshot and sequence number.
// Ports:
//   i_snap  in   NUM_CH*DATA_W  captured channel values, channel 0 in LSBs
//   i_seq   in   8              sequence number shown in the prefix
//   i_idx   in   IDX_W          byte index within the frame
//   o_byte  out  8              ASCII byte at that index

module framer_byte_sel
   import telemetry_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int DATA_W = 12,
   parameter int SEQ_EN = 1,
   parameter int IDX_W  = 6
) (
   input  logic [NUM_CH*DATA_W-1:0] i_snap,
   input  logic [7:0]               i_seq,
   input  logic [IDX_W-1:0]         i_idx,
   output logic [7:0]               o_byte
);

   localparam int DIGITS = hex_digits(DATA_W);
   localparam int FIELD  = DIGITS + 1;                    // digits plus trailing separator
   localparam int BODY   = 3 * SEQ_EN;                    // index of the first channel digit
   localparam int CR_POS = BODY + NUM_CH * FIELD - 1;     // the last channel's separator slot holds CR

   int                  w_pos;
   logic [4*DIGITS-1:0] w_pad;

   always_comb begin
      o_byte = 8'h00;
      w_pad  = '0;
      w_pos  = int'(i_idx);
      if (SEQ_EN != 0 && w_pos == 0) begin
         o_byte = hex_ascii(i_seq[7:4]);
      end else if (SEQ_EN != 0 && w_pos == 1) begin
         o_byte = hex_ascii(i_seq[3:0]);
      end else if (SEQ_EN != 0 && w_pos == 2) begin
         o_byte = COLON;
      end else if (w_pos == CR_POS) begin
         o_byte = CR;
      end else if (w_pos == CR_POS + 1) begin
         o_byte = LF;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_pos >= BODY + c * FIELD && w_pos < BODY + c * FIELD + DIGITS) begin
               // zero-pad to whole nibbles, then pick digits MSB first
               w_pad              = '0;
               w_pad[DATA_W-1:0]  = i_snap[c*DATA_W +: DATA_W];
               o_byte             = hex_ascii(w_pad[4*(BODY + c*FIELD + DIGITS - 1 - w_pos) +: 4]);
            end else if (w_pos == BODY + c * FIELD + DIGITS) begin
               o_byte = SP;
            end
         end
      end
   end

endmodule

// File: rtl/hex_telemetry_framer.sv
// rtl/hex_telemetry_framer.sv - snapshots sensor channels and sends them as one ASCII hex line
//
// Purpose: latches frame requests, decides whether to send (periodic or
// send-on-change), snapshots all channels in one cycle and streams the
// formatted line to a start/busy byte transmitter.
// Ports:
//   clk             in   1              system clock
//   rst_n           in   1              asynchronous active-low reset
//   ch_data         in   NUM_CH*DATA_W  channel values, channel 0 in LSBs
//   trigger         in   1              single-cycle frame request
//   send_on_change  in   1              1: trigger sends only if data changed
//   force_send      in   1              single-cycle unconditional frame request
//   tx_busy         in   1              transmitter busy
//   tx_start        out  1              single-cycle transmitter start pulse
//   tx_data         out  8              byte to transmit
//   frame_busy      out  1              high from snapshot through last byte
//   frame_done      out  1              pulse when the LF byte completes
//   seq_cnt         out  8              frames sent, wrapping

module hex_telemetry_framer
   import telemetry_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int DATA_W = 12,
   parameter int SEQ_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     trigger,
   input  logic                     send_on_change,
   input  logic                     force_send,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic                     frame_busy,
   output logic                     frame_done,
   output logic [7:0]               seq_cnt
);

   localparam int             FRAME_LEN   = frame_len(NUM_CH, DATA_W, SEQ_EN);
   localparam int             IDX_W       = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
   localparam logic [2:0]     ACK_TIMEOUT = 3'd3;   // four cycles in WAIT_ACK

   state_t                    r_state;
   state_t                    w_next;
   logic                      r_pending;
   logic                      r_pending_force;
   logic                      r_first;
   logic [NUM_CH*DATA_W-1:0]  r_snap;
   logic [NUM_CH*DATA_W-1:0]  r_last_sent;
   logic [7:0]                r_seq_cnt;
   logic [IDX_W-1:0]          r_idx;
   logic [2:0]                r_ack_cnt;
   logic [7:0]                r_tx_data;
   logic [7:0]                w_byte;
   logic                      w_send;
   logic                      w_last_byte;

   framer_byte_sel #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .SEQ_EN (SEQ_EN),
      .IDX_W  (IDX_W)
   ) u_byte_sel (
      .i_snap (r_snap),
      .i_seq  (r_seq_cnt),
      .i_idx  (r_idx),
      .o_byte (w_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      tx_start    = 1'b0;
      frame_busy  = 1'b0;
      frame_done  = 1'b0;
      w_send      = r_pending_force || !send_on_change || r_first || (ch_data != r_last_sent);
      w_last_byte = (r_idx == LAST_IDX);
      unique case (r_state)
         ST_IDLE: begin
            if (r_pending) w_next = ST_DECIDE;
         end
         ST_DECIDE: begin
            w_next = w_send ? ST_SNAP : ST_IDLE;
         end
         ST_SNAP: begin
            frame_busy = 1'b1;
            w_next     = ST_LOAD;
         end
         ST_LOAD: begin
            frame_busy = 1'b1;
            w_next     = ST_START;
         end
         ST_START: begin
            frame_busy = 1'b1;
            if (!tx_busy) begin
               tx_start = 1'b1;
               w_next   = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            frame_busy = 1'b1;
            if (tx_busy) begin
               w_next = ST_WAIT_DONE;
            end else if (r_ack_cnt == ACK_TIMEOUT) begin
               w_next = ST_START;   // transmitter ignored the pulse: send it again
            end
         end
         ST_WAIT_DONE: begin
            frame_busy = 1'b1;
            if (!tx_busy) begin
               if (w_last_byte) begin
                  frame_done = 1'b1;
                  // a request latched during the frame is decided without an idle cycle
                  w_next     = r_pending ? ST_DECIDE : ST_IDLE;
               end else begin
                  w_next = ST_LOAD;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending       <= 1'b0;
         r_pending_force <= 1'b0;
         r_first         <= 1'b1;
         r_snap          <= '0;
         r_last_sent     <= '0;
         r_seq_cnt       <= 8'h00;
         r_idx           <= '0;
         r_ack_cnt       <= 3'd0;
         r_tx_data       <= 8'h00;
      end else begin
         // clear first so that a request arriving in the same cycle is kept
         if (r_state == ST_SNAP || (r_state == ST_DECIDE && !w_send)) begin
            r_pending       <= 1'b0;
            r_pending_force <= 1'b0;
         end
         if (trigger || force_send) r_pending       <= 1'b1;
         if (force_send)            r_pending_force <= 1'b1;

         unique case (r_state)
            ST_SNAP: begin
               r_snap <= ch_data;
               r_idx  <= '0;
            end
            ST_LOAD: begin
               r_tx_data <= w_byte;
            end
            ST_START: begin
               r_ack_cnt <= 3'd0;
            end
            ST_WAIT_ACK: begin
               if (!tx_busy) r_ack_cnt <= r_ack_cnt + 3'd1;
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (w_last_byte) begin
                     r_last_sent <= r_snap;
                     r_first     <= 1'b0;
                     r_seq_cnt   <= r_seq_cnt + 8'd1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign tx_data = r_tx_data;
   assign seq_cnt = r_seq_cnt;

endmodule

// File: tb/tb_hex_telemetry_framer.sv
// tb/tb_hex_telemetry_framer.sv - self-checking bench for hex_telemetry_framer

module tb_hex_telemetry_framer;

   typedef logic [7:0] bq_t[$];

   logic        clk;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   // main instance (defaults: 5 ch, 12 bit, seq prefix)
   logic        rst_n, trig, soc, force_b, tx_busy;
   logic [59:0] ch_b;
   logic        tx_start, frame_busy, frame_done;
   logic [7:0]  tx_data, seq_cnt;

   // small instance (2 ch, 12 bit, no prefix)
   logic        rst_a, trig_a, a_busy;
   logic [23:0] ch_a;
   logic        a_tx_start, a_frame_busy, a_frame_done;
   logic [7:0]  a_tx_data, a_seq;

   // bench transmitter / model state
   bit          accept = 1;
   bit          hold_busy = 0;
   bit          acc_seen = 0;
   int          busy_left = 0;
   bit          in_frame = 0;
   bit          prev_fb = 0;
   int          pos = 0;
   int          m_seq = 0;
   int          n_start = 0;
   int          n_done = 0;
   int          rise_cyc = 0;
   int          done_cyc = 0;
   bq_t         exp_q;
   bq_t         got;
   int          start_cyc[$];
   logic [7:0]  start_dat[$];

   bit          a_go = 0;
   int          a_left = 0;
   int          a_starts = 0;
   int          a_dones = 0;
   bit          a_fin = 0;
   bq_t         a_bytes;

   hex_telemetry_framer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ch_data        (ch_b),
      .trigger        (trig),
      .send_on_change (soc),
      .force_send     (force_b),
      .tx_busy        (tx_busy),
      .tx_start       (tx_start),
      .tx_data        (tx_data),
      .frame_busy     (frame_busy),
      .frame_done     (frame_done),
      .seq_cnt        (seq_cnt)
   );

   hex_telemetry_framer #(.NUM_CH(2), .DATA_W(12), .SEQ_EN(0)) dut_a (
      .clk            (clk),
      .rst_n          (rst_a),
      .ch_data        (ch_a),
      .trigger        (trig_a),
      .send_on_change (1'b0),
      .force_send     (1'b0),
      .tx_busy        (a_busy),
      .tx_start       (a_tx_start),
      .tx_data        (a_tx_data),
      .frame_busy     (a_frame_busy),
      .frame_done     (a_frame_done),
      .seq_cnt        (a_seq)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input bit ok, input string name, input longint act, input longint want);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // expected line built straight from the text format
   function automatic bq_t build_frame(input int nch, input int dw, input int seq_en,
                                       input logic [127:0] snap, input int seq);
      bq_t          f;
      string        hx;
      int           dg;
      logic [127:0] v;
      hx = "0123456789ABCDEF";
      dg = (dw + 3) / 4;
      f  = {};
      if (seq_en != 0) begin
         f.push_back(8'(hx[(seq >> 4) & 15]));
         f.push_back(8'(hx[seq & 15]));
         f.push_back(8'h3A);
      end
      for (int c = 0; c < nch; c++) begin
         v = (snap >> (c * dw)) & ((128'd1 << dw) - 128'd1);
         for (int k = dg - 1; k >= 0; k--) f.push_back(8'(hx[int'((v >> (4 * k)) & 128'hF)]));
         if (c < nch - 1) f.push_back(8'h20);
      end
      f.push_back(8'h0D);
      f.push_back(8'h0A);
      return f;
   endfunction

   function automatic logic [7:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 8'h00;
   endfunction

   // compare process for the main instance
   always @(negedge clk) begin
      acc_seen = 0;
      if (!rst_n) begin
         m_seq    = 0;
         in_frame = 0;
         pos      = 0;
         prev_fb  = 0;
      end else begin
         if (frame_busy && !prev_fb) begin
            exp_q    = build_frame(5, 12, 1, 128'(ch_b), m_seq);
            pos      = 0;
            in_frame = 1;
            got      = {};
            rise_cyc = cyc;
         end
         if (tx_busy && in_frame && pos > 0)
            check(tx_data == exp_q[pos-1], "tx_data_hold", tx_data, exp_q[pos-1]);
         if (tx_start) begin
            n_start++;
            start_cyc.push_back(cyc);
            start_dat.push_back(tx_data);
            check(in_frame && frame_busy, "start_in_frame", frame_busy, 1);
            check(!tx_busy, "start_while_busy", tx_busy, 0);
            if (in_frame && pos < exp_q.size())
               check(tx_data == exp_q[pos], $sformatf("byte%0d", pos), tx_data, exp_q[pos]);
            if (accept) begin
               acc_seen = 1;
               if (in_frame) begin
                  got.push_back(tx_data);
                  pos++;
               end
            end
         end
         if (frame_done) begin
            check(pos == exp_q.size(), "frame_len", pos, exp_q.size());
            check(seq_cnt == 8'(m_seq), "seq_cnt", seq_cnt, m_seq);
            m_seq    = (m_seq + 1) % 256;
            n_done++;
            done_cyc = cyc;
            in_frame = 0;
         end
         prev_fb = frame_busy;
      end
   end

   // transmitter model: busy for three cycles after an accepted start
   always @(posedge clk) begin
      #1;
      if (hold_busy) begin
         tx_busy = 1'b1;
      end else if (acc_seen) begin
         busy_left = 3;
         tx_busy   = 1'b1;
      end else if (busy_left > 1) begin
         busy_left--;
      end else begin
         busy_left = 0;
         tx_busy   = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (a_tx_start) begin
         a_bytes.push_back(a_tx_data);
         a_starts++;
         a_go = 1;
      end
      if (a_frame_done) a_dones++;
   end

   always @(posedge clk) begin
      #1;
      if (a_go) begin
         a_left = 3;
         a_busy = 1'b1;
         a_go   = 0;
      end else if (a_left > 1) begin
         a_left--;
      end else begin
         a_left = 0;
         a_busy = 1'b0;
      end
   end

   // small instance: single frame against literal bytes
   initial begin
      logic [7:0] a_lit [9];
      bq_t        mf;
      int         k;
      a_lit  = '{8'h41, 8'h42, 8'h43, 8'h20, 8'h30, 8'h35, 8'h46, 8'h0D, 8'h0A};
      rst_a  = 0;
      trig_a = 0;
      a_busy = 0;
      ch_a   = {12'h05F, 12'hABC};
      repeat (3) @(posedge clk);
      #1 rst_a = 1;
      @(posedge clk); #1 trig_a = 1;
      @(posedge clk); #1 trig_a = 0;
      k = 0;
      while (a_dones < 1 && k < 400) begin @(negedge clk); k++; end
      repeat (100) @(negedge clk);
      mf = build_frame(2, 12, 0, 128'(ch_a), 0);
      check(a_bytes.size() == 9, "a_byte_count", a_bytes.size(), 9);
      check(a_starts == 9, "a_starts", a_starts, 9);
      check(a_dones == 1, "a_frame_done", a_dones, 1);
      check(a_seq == 8'd1, "a_seq_cnt", a_seq, 1);
      for (int i = 0; i < 9; i++) begin
         check(mf.size() > i && mf[i] == a_lit[i], $sformatf("model_lit%0d", i),
               (mf.size() > i) ? mf[i] : 8'h00, a_lit[i]);
         check(a_bytes.size() > i && a_bytes[i] == a_lit[i], $sformatf("a_byte%0d", i),
               (a_bytes.size() > i) ? a_bytes[i] : 8'h00, a_lit[i]);
      end
      a_fin = 1;
   end

   task automatic pulse_trig();
      @(posedge clk); #1 trig = 1;
      @(posedge clk); #1 trig = 0;
   endtask

   task automatic pulse_force();
      @(posedge clk); #1 force_b = 1;
      @(posedge clk); #1 force_b = 0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin @(negedge clk); k++; end
      check(n_done >= target, "frame_timeout", n_done, target);
   endtask

   task automatic wait_pos(input int n);
      int k = 0;
      while (!(in_frame && pos >= n) && k < 1000) begin @(negedge clk); k++; end
      check(in_frame && pos >= n, "pos_timeout", pos, n);
   endtask

   initial begin
      logic [59:0] vecs [5];
      int          d0, s0, dc1, k;
      vecs = '{60'h0, 60'hFFF_FFF_FFF_FFF_FFF, 60'h9A0_5F1_E2D_C3B_4A8,
               60'h001_010_100_A0B_FED, 60'h00F_ABC_789_456_123};
      rst_n   = 0;
      trig    = 0;
      soc     = 0;
      force_b = 0;
      tx_busy = 0;
      ch_b    = '0;
      repeat (3) @(posedge clk);
      #1;
      check(tx_start == 0, "rst_tx_start", tx_start, 0);
      check(tx_data == 0, "rst_tx_data", tx_data, 0);
      check(frame_busy == 0, "rst_frame_busy", frame_busy, 0);
      check(frame_done == 0, "rst_frame_done", frame_done, 0);
      check(seq_cnt == 0, "rst_seq_cnt", seq_cnt, 0);
      rst_n = 1;

      // periodic frames, the fifth pinned by hand
      for (int f = 0; f < 5; f++) begin
         ch_b = vecs[f];
         pulse_trig();
         wait_frames(n_done + 1, 1000);
      end
      repeat (2) @(negedge clk);
      check(got.size() == 24, "f5_len", got.size(), 24);
      check(got_at(0) == 8'h30, "f5_seq_hi", got_at(0), 8'h30);
      check(got_at(1) == 8'h34, "f5_seq_lo", got_at(1), 8'h34);
      check(got_at(2) == 8'h3A, "f5_colon", got_at(2), 8'h3A);
      check(got_at(3) == 8'h31 && got_at(4) == 8'h32 && got_at(5) == 8'h33,
            "f5_ch0", {got_at(3), got_at(4), got_at(5)}, 24'h313233);
      check(got_at(6) == 8'h20, "f5_sep", got_at(6), 8'h20);
      check(seq_cnt == 8'd5, "f5_seq_cnt", seq_cnt, 5);

      // send on change
      soc = 1;
      s0  = n_start;
      d0  = n_done;
      repeat (3) begin
         pulse_trig();
         repeat (10) @(posedge clk);
      end
      check(n_start == s0, "soc_unchanged", n_start - s0, 0);
      #1 ch_b[35:24] = ch_b[35:24] + 12'd1;
      pulse_trig();
      wait_frames(d0 + 1, 1000);
      repeat (20) @(negedge clk);
      check(n_done == d0 + 1, "soc_changed_frames", n_done - d0, 1);
      check(n_start - s0 == 24, "soc_changed_starts", n_start - s0, 24);
      s0 = n_start;
      d0 = n_done;
      pulse_force();
      wait_frames(d0 + 1, 1000);
      repeat (20) @(negedge clk);
      check(n_done == d0 + 1, "force_frames", n_done - d0, 1);
      check(n_start - s0 == 24, "force_starts", n_start - s0, 24);

      // requests during a frame and mid-frame data change
      soc = 0;
      d0  = n_done;
      pulse_trig();
      wait_pos(2);
      pulse_trig();
      wait_pos(5);
      pulse_trig();
      ch_b = ch_b ^ 60'h5A5_5A5_5A5_5A5_5A5;
      wait_frames(d0 + 1, 1000);
      dc1 = done_cyc;
      wait_frames(d0 + 2, 1000);
      repeat (80) @(negedge clk);
      check(n_done == d0 + 2, "followup_count", n_done - d0, 2);
      check(rise_cyc - dc1 == 2, "followup_gap", rise_cyc - dc1, 2);

      // transmitter ignores starts, then stays busy
      d0 = n_done;
      pulse_trig();
      wait_pos(3);
      @(posedge clk);
      #1 accept = 0;
      start_cyc = {};
      start_dat = {};
      k = 0;
      while (start_cyc.size() < 3 && k < 100) begin @(negedge clk); k++; end
      check(start_cyc.size() >= 3, "stall_repulse", start_cyc.size(), 3);
      if (start_cyc.size() >= 3) begin
         check(start_cyc[1] - start_cyc[0] == 5, "stall_gap1", start_cyc[1] - start_cyc[0], 5);
         check(start_cyc[2] - start_cyc[1] == 5, "stall_gap2", start_cyc[2] - start_cyc[1], 5);
         check(start_dat[1] == start_dat[0] && start_dat[2] == start_dat[0], "stall_data",
               {start_dat[1], start_dat[2]}, {start_dat[0], start_dat[0]});
      end
      @(posedge clk);
      #1 accept = 1;
      k = 0;
      @(negedge clk);
      while (!tx_start && k < 100) begin @(negedge clk); k++; end
      hold_busy = 1;
      @(negedge clk);
      s0 = n_start;
      repeat (99) @(negedge clk);
      check(n_start == s0, "hold_no_start", n_start - s0, 0);
      hold_busy = 0;
      wait_frames(d0 + 1, 1000);

      // reset in the middle of a frame
      repeat (10) @(posedge clk);
      #1 pulse_trig();
      wait_pos(4);
      #2 rst_n = 0;
      #1;
      check(tx_start == 0, "midrst_tx_start", tx_start, 0);
      check(tx_data == 0, "midrst_tx_data", tx_data, 0);
      check(frame_busy == 0, "midrst_frame_busy", frame_busy, 0);
      check(frame_done == 0, "midrst_frame_done", frame_done, 0);
      check(seq_cnt == 0, "midrst_seq_cnt", seq_cnt, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      repeat (20) @(posedge clk);
      #1;
      soc  = 1;
      ch_b = '0;
      d0   = n_done;
      pulse_trig();
      wait_frames(d0 + 1, 1000);
      repeat (2) @(negedge clk);
      check(got_at(0) == 8'h30 && got_at(1) == 8'h30, "postrst_seq",
            {got_at(0), got_at(1)}, 16'h3030);
      check(seq_cnt == 8'd1, "postrst_seq_cnt", seq_cnt, 1);

      k = 0;
      while (!a_fin && k < 1000) begin @(negedge clk); k++; end
      check(a_fin, "small_instance_timeout", a_fin, 1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
